gray_sobel: RTL and testbench
=============================

Name: gray_sobel

Overview:
Downstream consumer of the RGB565-to-gray stage. Takes the 8-bit gray pixel stream with its valid strobe and computes a 3x3 Sobel edge magnitude per pixel using two line buffers. Emits one 8-bit edge value per accepted pixel with fixed latency, feeding display/binarisation logic. Raster order is tracked internally by column/row counters resynchronised by a frame pulse.

Parameters:
IMG_WIDTH, 640, active pixels per line (>=3)
IMG_HEIGHT, 480, active lines per frame (>=3)
EDGE_THRESH, 8'd64, binarisation threshold (used only with SOBEL_BINARY_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
gray_in  input  8  gray pixel, raster order
pixel_valid_in  input  1  gray_in valid this cycle; gaps allowed, no backpressure
frame_sync_in  input  1  single-cycle pulse; forces next accepted pixel to (row 0, col 0)
edge_out  output  8  edge magnitude (or binary 0/255)
pixel_valid_out  output  1  edge_out valid this cycle

Behaviour:
- Reset (async, rst_n low): edge_out=0, pixel_valid_out=0, col=0, row=0, all window/pipeline regs and valid tags 0. Line buffer RAM contents not cleared; border forcing makes them irrelevant.
- Counters: advance only on pixel_valid_in. col wraps IMG_WIDTH-1 -> 0 and increments row; row wraps IMG_HEIGHT-1 -> 0.
- frame_sync_in without valid: col=row=0 next cycle. With pixel_valid_in in same cycle: that pixel is (0,0), counters then advance to (0,1). Sync takes priority over wrap.
- Line buffers: two IMG_WIDTH x 8 buffers addressed by col; on valid, read old contents (rows y-1, y-2) and write gray_in / row y-1 value. Read-before-write at same address.
- Window: 3x3 shift register p[r][c] (r=0 top, c=2 newest) shifts only on pixel_valid_in. Window bottom-right = current input pixel (y,x).
- Arithmetic: Gx=(p02+2p12+p22)-(p00+2p10+p20), Gy=(p20+2p21+p22)-(p00+2p01+p02); 11-bit signed, range +/-1020. mag=|Gx|+|Gy| 11-bit unsigned, max 2040; edge = mag>255 ? 255 : mag[7:0].
- Border: if row<2 or col<2 for the input pixel, edge forced to 0 (output count per frame equals input count).
- Pipeline: valid-tagged, free-running; stage1 window/line-buffer capture, stage2 Gx/Gy, stage3 magnitude+saturate into edge_out. pixel_valid_out asserts exactly 3 clk after corresponding pixel_valid_in, independent of gaps. Back-to-back valids give back-to-back outputs.
- pixel_valid_out low: edge_out holds last value.
- Reset mid-frame: pipeline flushed, no stale valid emitted; next pixel treated as (0,0).

Optional Feature:
SOBEL_BINARY_EN defined: edge_out = (saturated mag >= EDGE_THRESH) ? 8'd255 : 8'd0; border pixels still 0; latency unchanged (compare folded into stage3).
Undefined: edge_out = saturated magnitude; EDGE_THRESH unused.

Decomposition:
- Shared package: PIX_W=8, GRAD_W=11 (signed gradient width), MAG_MAX=8'd255, counter width function clog2(IMG_WIDTH)/clog2(IMG_HEIGHT).
- Sub-module gray_line_buffer: single-port read-before-write RAM, parameters DEPTH, WIDTH; instantiated once at WIDTH=16 (both rows) or twice at WIDTH=8.

Test Plan (bench uses IMG_WIDTH=8, IMG_HEIGHT=6):
- Flat frame gray_in=100 all pixels, continuous valid -> 48 outputs, all edge_out=0, each 3 clk after input.
- Vertical step: cols 0-3=0, cols 4-7=200 -> rows 2-5: col 4 and col 5 outputs =255 (Gx=800 saturated), cols 2,3,6,7 =0; rows 0-1 all 0.
- Column ramp gray=10*col -> interior outputs (row>=2,col>=2) =80; with SOBEL_BINARY_EN, EDGE_THRESH=64 -> 255; EDGE_THRESH=81 -> 0.
- Same step frame with 1-3 random idle cycles between pixels -> identical output values/order, each pixel_valid_out exactly 3 clk after its input.
- frame_sync_in pulsed after 20 pixels, then full frame -> counters restart; first two rows of new frame all 0, results match clean-frame reference.
- rst_n low for 2 clk mid-frame while valid streaming -> edge_out=0, pixel_valid_out=0 during reset and no output for pixels in flight; after release next pixel is (0,0) and new frame results correct.

Source files
------------

// File: rtl/gray_sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gray_sobel_pkg
//  Purpose  : Shared widths, types and helpers for the gray_sobel edge stage.
//             PIX_W   - gray pixel width
//             GRAD_W  - signed gradient width (holds +/-1020)
//             MAG_MAX - saturated edge value
//             cnt_w() - counter width for a given count
//  Revision : 1.0 - initial release
// ============================================================================
package gray_sobel_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam logic [PIX_W-1:0] MAG_MAX = 8'd255;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;

    // Bits needed to count 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Zero-extend an unsigned pixel into the signed gradient domain.
    function automatic grad_t pix_ext(input pix_t p);
        return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : gray_line_buffer
//  Purpose  : Single-port line RAM with asynchronous read and clocked write.
//             The read port shows the old word during the write cycle, giving
//             read-before-write behaviour at the same address.
//  Ports    : clk   - clock
//             we    - write enable
//             addr  - word address (0..DEPTH-1)
//             wdata - word written on clk when we is high
//             rdata - current contents at addr
//  Revision : 1.0 - initial release
// ============================================================================
module gray_line_buffer
    import gray_sobel_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [cnt_w(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata
);

    // Contents are intentionally not reset; the consumer masks stale data.
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign rdata = r_mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gray_sobel.sv
`default_nettype none
// ============================================================================
//  Module   : gray_sobel
//  Purpose  : 3x3 Sobel edge magnitude on an 8-bit gray raster stream.
//             Three-stage valid-tagged pipeline: window capture, gradients,
//             magnitude/saturate. Output follows input by exactly 3 clocks.
//             Pixels in the first two rows/columns produce 0.
//  Macro    : SOBEL_BINARY_EN - when defined, output is 255 if the saturated
//             magnitude >= EDGE_THRESH, else 0.
//  Ports    : clk             - clock
//             rst_n           - asynchronous active-low reset
//             gray_in         - gray pixel, raster order
//             pixel_valid_in  - gray_in valid (gaps allowed)
//             frame_sync_in   - pulse; next accepted pixel is (row 0, col 0)
//             edge_out        - edge value (held while pixel_valid_out low)
//             pixel_valid_out - edge_out valid
//  Revision : 1.0 - initial release
// ============================================================================
module gray_sobel
    import gray_sobel_pkg::*;
#(
    parameter int              IMG_WIDTH   = 640,
    parameter int              IMG_HEIGHT  = 480,
    parameter logic [7:0]      EDGE_THRESH = 8'd64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   gray_in,
    input  logic               pixel_valid_in,
    input  logic               frame_sync_in,
    output logic [PIX_W-1:0]   edge_out,
    output logic               pixel_valid_out
);

    localparam int COL_W = cnt_w(IMG_WIDTH);
    localparam int ROW_W = cnt_w(IMG_HEIGHT);
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // ------------------------------------------------------------------
    // Raster position of the pixel presented this cycle
    // ------------------------------------------------------------------
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_border;

    // A sync in the same cycle as a valid pixel makes that pixel (0,0).
    assign w_col    = frame_sync_in ? '0 : r_col;
    assign w_row    = frame_sync_in ? '0 : r_row;
    assign w_border = (w_row < ROW_W'(2)) || (w_col < COL_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (frame_sync_in) begin
            r_row <= '0;
            r_col <= pixel_valid_in ? COL_W'(1) : '0;
        end else if (pixel_valid_in) begin
            if (r_col == C_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: one 16-bit word per column holds {row y-2, row y-1}.
    // Writing {row y-1, gray_in} ages both rows by one line.
    // ------------------------------------------------------------------
    logic [2*PIX_W-1:0] w_lb_rd;
    logic [2*PIX_W-1:0] w_lb_wr;

    assign w_lb_wr = {w_lb_rd[PIX_W-1:0], gray_in};

    gray_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (2*PIX_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (pixel_valid_in),
        .addr  (w_col),
        .wdata (w_lb_wr),
        .rdata (w_lb_rd)
    );

    // ------------------------------------------------------------------
    // Stage 1: 3x3 window, column 2 newest, row 2 = current line
    // ------------------------------------------------------------------
    pix_t r_win [3][3];
    logic r_v1;
    logic r_border1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            r_v1      <= 1'b0;
            r_border1 <= 1'b0;
        end else begin
            r_v1 <= pixel_valid_in;
            if (pixel_valid_in) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb_rd[2*PIX_W-1:PIX_W];
                r_win[1][2] <= w_lb_rd[PIX_W-1:0];
                r_win[2][2] <= gray_in;
                r_border1   <= w_border;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: gradients
    // ------------------------------------------------------------------
    grad_t w_gx;
    grad_t w_gy;
    grad_t r_gx;
    grad_t r_gy;
    logic  r_v2;
    logic  r_border2;

    assign w_gx = (pix_ext(r_win[0][2]) + (pix_ext(r_win[1][2]) <<< 1) + pix_ext(r_win[2][2]))
                - (pix_ext(r_win[0][0]) + (pix_ext(r_win[1][0]) <<< 1) + pix_ext(r_win[2][0]));
    assign w_gy = (pix_ext(r_win[2][0]) + (pix_ext(r_win[2][1]) <<< 1) + pix_ext(r_win[2][2]))
                - (pix_ext(r_win[0][0]) + (pix_ext(r_win[0][1]) <<< 1) + pix_ext(r_win[0][2]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gx      <= '0;
            r_gy      <= '0;
            r_v2      <= 1'b0;
            r_border2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_gx      <= w_gx;
                r_gy      <= w_gy;
                r_border2 <= r_border1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: |Gx|+|Gy|, saturate, optional threshold
    // ------------------------------------------------------------------
    logic [GRAD_W-1:0] w_abs_x;
    logic [GRAD_W-1:0] w_abs_y;
    logic [GRAD_W-1:0] w_mag;
    pix_t              w_sat;
    pix_t              w_edge;

    // Magnitudes never exceed 1020, so negation cannot overflow.
    assign w_abs_x = r_gx[GRAD_W-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
    assign w_abs_y = r_gy[GRAD_W-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
    assign w_mag   = w_abs_x + w_abs_y;
    assign w_sat   = (|w_mag[GRAD_W-1:PIX_W]) ? MAG_MAX : w_mag[PIX_W-1:0];

`ifdef SOBEL_BINARY_EN
    assign w_edge = (w_sat >= EDGE_THRESH) ? MAG_MAX : '0;
`else
    assign w_edge = w_sat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_out        <= '0;
            pixel_valid_out <= 1'b0;
        end else begin
            pixel_valid_out <= r_v2;
            if (r_v2) begin
                edge_out <= r_border2 ? '0 : w_edge;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_sobel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_sobel
//  Purpose  : Scoreboard bench for gray_sobel on an 8x6 image. A raster
//             model computes each expected edge value directly from a stored
//             image; a monitor pops and compares on every output strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gray_sobel;

    localparam int         W  = 8;
    localparam int         H  = 6;
    localparam logic [7:0] TH = 8'd64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gray_in = '0;
    logic       pixel_valid_in = 1'b0;
    logic       frame_sync_in = 1'b0;
    logic [7:0] edge_out;
    logic       pixel_valid_out;

    gray_sobel #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .EDGE_THRESH (TH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gray_in         (gray_in),
        .pixel_valid_in  (pixel_valid_in),
        .frame_sync_in   (frame_sync_in),
        .edge_out        (edge_out),
        .pixel_valid_out (pixel_valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] val;
        int         cyc;
        int         y;
        int         x;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         img [H][W];
    int         by = 0;
    int         bx = 0;
    logic [7:0] last_val = '0;

    // Reference: Sobel evaluated straight from the stored image.
    function automatic logic [7:0] ref_edge(input int y, input int x);
        int gx, gy, mag;
        if (y < 2 || x < 2) return 8'd0;
        gx = (img[y-2][x] + 2*img[y-1][x] + img[y][x])
           - (img[y-2][x-2] + 2*img[y-1][x-2] + img[y][x-2]);
        gy = (img[y][x-2] + 2*img[y][x-1] + img[y][x])
           - (img[y-2][x-2] + 2*img[y-2][x-1] + img[y-2][x]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
`ifdef SOBEL_BINARY_EN
        return (mag >= int'(TH)) ? 8'd255 : 8'd0;
`else
        return 8'(mag);
`endif
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            total++;
            if (edge_out !== 8'd0 || pixel_valid_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs: edge_out=%0d pixel_valid_out=%b, required 0/0",
                         edge_out, pixel_valid_out);
            end
            last_val = '0;
        end else begin
            if (pixel_valid_out === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: edge_out=%0d at cycle %0d, required no output",
                             edge_out, cyc);
                end else begin
                    e = q.pop_front();
                    if (edge_out !== e.val || cyc != e.cyc + 3) begin
                        bad++;
                        $display("FAIL edge(%0d,%0d): edge_out=%0d latency=%0d, required %0d latency=3",
                                 e.y, e.x, edge_out, cyc - e.cyc, e.val);
                    end
                end
                last_val = edge_out;
            end else begin
                total++;
                if (edge_out !== last_val) begin
                    bad++;
                    $display("FAIL hold: edge_out=%0d while idle, required %0d", edge_out, last_val);
                end
            end
            while (q.size() > 0 && cyc > q[0].cyc + 3) begin
                total++;
                bad++;
                $display("FAIL missing_output(%0d,%0d): no pixel_valid_out by cycle %0d, required at %0d",
                         q[0].y, q[0].x, cyc, q[0].cyc + 3);
                void'(q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_px(input logic [7:0] g, input bit sync);
        exp_t e;
        if (sync) begin
            by = 0;
            bx = 0;
        end
        img[by][bx] = int'(g);
        e.val = ref_edge(by, bx);
        e.cyc = cyc;
        e.y   = by;
        e.x   = bx;
        q.push_back(e);
        gray_in        = g;
        pixel_valid_in = 1'b1;
        frame_sync_in  = sync;
        if (bx == W - 1) begin
            bx = 0;
            by = (by == H - 1) ? 0 : by + 1;
        end else begin
            bx++;
        end
        @(posedge clk);
        #1;
        pixel_valid_in = 1'b0;
        frame_sync_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] pattern(input int kind, input int x);
        case (kind)
            0:       return 8'd100;
            1:       return (x >= 4) ? 8'd200 : 8'd0;
            2:       return 8'(10 * x);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // One full frame; optional sync on the first pixel and random gaps.
    task automatic frame(input int kind, input bit gaps, input bit sync_first);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                drive_px(pattern(kind, x), sync_first && y == 0 && x == 0);
                if (gaps) idle(int'($urandom_range(1, 3)));
            end
        end
    endtask

    task automatic sync_only();
        frame_sync_in = 1'b1;
        by = 0;
        bx = 0;
        @(posedge clk);
        #1;
        frame_sync_in = 1'b0;
    endtask

    task automatic mid_reset();
        for (int i = 0; i < 30; i++) drive_px(8'($urandom_range(0, 255)), 1'b0);
        rst_n          = 1'b0;
        q.delete();
        by             = 0;
        bx             = 0;
        pixel_valid_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            gray_in = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        rst_n          = 1'b1;
        pixel_valid_in = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        frame(0, 1'b0, 1'b0);          // flat
        frame(1, 1'b0, 1'b0);          // vertical step
        frame(2, 1'b0, 1'b0);          // column ramp
        frame(1, 1'b1, 1'b0);          // step with gaps
        idle(5);

        for (int i = 0; i < 20; i++) drive_px(8'($urandom_range(0, 255)), 1'b0);
        idle(2);
        sync_only();
        frame(1, 1'b0, 1'b0);          // clean frame after standalone sync

        for (int i = 0; i < 13; i++) drive_px(8'($urandom_range(0, 255)), 1'b0);
        frame(3, 1'b0, 1'b1);          // sync coincident with first pixel

        mid_reset();
        frame(3, 1'b0, 1'b0);
        frame(3, 1'b1, 1'b0);
        frame(2, 1'b1, 1'b0);

        idle(8);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected outputs outstanding, required 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
